// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: instruction (I) and data (D) masters share one
// AXI read port, one burst outstanding at a time, round-robin on contention.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  // Instruction-side requester
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,

  // Data-side requester
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,

  // Shared master read-address channel
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic        m_arvalid,
  input  logic        m_arready,

  // Shared master read-data channel
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,

  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e      state_q;
  logic        owner_q;
  logic        prev_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic        owner_d;
  logic        in_addr;
  logic        in_data;
  logic        ar_hs;
  logic        r_hs;
  logic        beat_err;
  logic [3:0]  owner_id;

  // Round-robin pick: on a tie the side that did not win last time goes next.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    owner_d = owner_q;
    if (i_arvalid && d_arvalid) begin
      owner_d = ~prev_q;
    end else if (d_arvalid) begin
      owner_d = OWN_D;
    end else if (i_arvalid) begin
      owner_d = OWN_I;
    end
  end

  assign in_addr  = (state_q == ADDR);
  assign in_data  = (state_q == DATA);
  assign owner_id = (owner_q == OWN_D) ? ID_D : ID_I;
  assign ar_hs    = in_addr && m_arready;
  assign r_hs     = in_data && m_rvalid && m_rready;

  // A beat is malformed if rlast disagrees with the remaining-beat count or
  // the returned ID is not the one we issued.
  assign beat_err = (m_rlast && (cnt_q != 8'd0))
                 || (!m_rlast && (cnt_q == 8'd0))
                 || (m_rid != owner_id);

  // NOTE: state registers use non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      prev_q  <= OWN_I;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_arvalid || d_arvalid) begin
            owner_q <= owner_d;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            cnt_q   <= (owner_q == OWN_D) ? d_arlen : i_arlen;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q - 8'd1;
            if (beat_err) begin
              err_q <= 1'b1;
            end
            // Only rlast ends the burst, even if the count says otherwise.
            if (m_rlast) begin
              prev_q  <= owner_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address channel: fields are forced to zero outside ADDR.
  assign m_arvalid = in_addr;
  assign m_arid    = in_addr ? owner_id : 4'd0;
  assign m_araddr  = !in_addr ? 32'd0 : ((owner_q == OWN_D) ? d_araddr : i_araddr);
  assign m_arlen   = !in_addr ? 8'd0  : ((owner_q == OWN_D) ? d_arlen  : i_arlen);
  assign m_arsize  = !in_addr ? 3'd0  : ((owner_q == OWN_D) ? d_arsize : i_arsize);
  assign i_arready = in_addr && (owner_q == OWN_I) && m_arready;
  assign d_arready = in_addr && (owner_q == OWN_D) && m_arready;

  // Data channel: only the owner sees beats, and only while in DATA.
  assign m_rready = in_data && ((owner_q == OWN_D) ? d_rready : i_rready);
  assign i_rvalid = in_data && (owner_q == OWN_I) && m_rvalid;
  assign i_rlast  = in_data && (owner_q == OWN_I) && m_rlast;
  assign i_rdata  = (in_data && (owner_q == OWN_I)) ? m_rdata : 32'd0;
  assign d_rvalid = in_data && (owner_q == OWN_D) && m_rvalid;
  assign d_rlast  = in_data && (owner_q == OWN_D) && m_rlast;
  assign d_rdata  = (in_data && (owner_q == OWN_D)) ? m_rdata : 32'd0;

  assign err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of burst scenarios with hand-picked
// winners, plus sequences for stall, early rlast, bad ID and mid-burst reset.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic        i_arvalid, d_arvalid;
  logic        i_arready, d_arready;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rlast, d_rlast;
  logic        i_rvalid, d_rvalid;
  logic        i_rready, d_rready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic        m_rlast, m_rvalid, m_rready;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_I(4'd0), .ID_D(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .err(err)
  );

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [7:0]  i_len;
    logic [7:0]  d_len;
    logic [2:0]  i_size;
    logic [2:0]  d_size;
    logic        exp_owner;  // 0 = I, 1 = D
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request pattern, check the grant, then play the slave side of
  // the burst. early_last >= 0 raises m_rlast on that beat index instead of
  // the real last one; stall_at/stall_len hold owner rready low mid-burst.
  task automatic run_burst(input vec_t v, input int early_last, input bit bad_rid,
                           input int stall_at, input int stall_len, input logic exp_err);
    logic [3:0]  id;
    logic [7:0]  len;
    logic [31:0] data;
    int          last;
    id  = v.exp_owner ? 4'd1 : 4'd0;
    len = v.exp_owner ? v.d_len : v.i_len;
    last = (early_last >= 0) ? early_last : int'(len);

    i_araddr = v.i_addr;  i_arlen = v.i_len;  i_arsize = v.i_size;
    d_araddr = v.d_addr;  d_arlen = v.d_len;  d_arsize = v.d_size;
    i_arvalid = v.i_req;  d_arvalid = v.d_req;
    i_rready = 1'b1;      d_rready = 1'b1;
    m_arready = 1'b0;
    #1;
    check("idle_arvalid", m_arvalid, 1'b0);

    tick();
    m_arready = 1'b1;
    #1;
    check("addr_arvalid", m_arvalid, 1'b1);
    check("addr_arid", m_arid, id);
    check("addr_araddr", m_araddr, v.exp_owner ? v.d_addr : v.i_addr);
    check("addr_arlen", m_arlen, len);
    check("addr_arsize", m_arsize, v.exp_owner ? v.d_size : v.i_size);
    check("owner_arready", v.exp_owner ? d_arready : i_arready, 1'b1);
    check("other_arready", v.exp_owner ? i_arready : d_arready, 1'b0);

    tick();
    m_arready = 1'b0;
    if (v.exp_owner) d_arvalid = 1'b0;
    else i_arvalid = 1'b0;

    for (int b = 0; b <= last; b++) begin
      data = 32'hC0DE_0000 | (32'(v.exp_owner) << 12) | 32'(b);
      m_rvalid = 1'b1;
      m_rdata  = data;
      m_rlast  = (b == last);
      m_rid    = bad_rid ? ~id : id;
      if (b == stall_at) begin
        if (v.exp_owner) d_rready = 1'b0;
        else i_rready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_m_rready", m_rready, 1'b0);
          check("stall_rvalid", v.exp_owner ? d_rvalid : i_rvalid, 1'b1);
          tick();
        end
        i_rready = 1'b1;
        d_rready = 1'b1;
      end
      #1;
      check("beat_m_rready", m_rready, 1'b1);
      check("beat_rvalid", v.exp_owner ? d_rvalid : i_rvalid, 1'b1);
      check("beat_rdata", v.exp_owner ? d_rdata : i_rdata, data);
      check("beat_rlast", v.exp_owner ? d_rlast : i_rlast, (b == last));
      check("other_rvalid", v.exp_owner ? i_rvalid : d_rvalid, 1'b0);
      check("other_rdata", v.exp_owner ? i_rdata : d_rdata, 32'd0);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("post_m_rready", m_rready, 1'b0);
    check("post_arvalid", m_arvalid, 1'b0);
    check("post_err", err, exp_err);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    rst = 1'b1;
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    // Losers keep requesting into the next row, so every row is protocol-legal.
    vecs[0] = '{1, 1, 32'h2000, 32'h3000, 8'd1, 8'd2, 3'd2, 3'd1, 1'b1}; // reset tie -> D
    vecs[1] = '{1, 1, 32'h2000, 32'h3100, 8'd1, 8'd0, 3'd2, 3'd2, 1'b0}; // -> I
    vecs[2] = '{1, 1, 32'h2100, 32'h3100, 8'd2, 8'd0, 3'd2, 3'd2, 1'b1}; // -> D
    vecs[3] = '{1, 0, 32'h2100, 32'h0,    8'd2, 8'd0, 3'd2, 3'd0, 1'b0}; // -> I
    vecs[4] = '{0, 1, 32'h0,    32'h4000, 8'd0, 8'd0, 3'd0, 3'd0, 1'b1}; // D alone, 1 beat
    vecs[5] = '{1, 0, 32'h1000, 32'h0,    8'd7, 8'd0, 3'd2, 3'd0, 1'b0}; // I alone, 8 beats
    vecs[6] = '{1, 1, 32'h5000, 32'h6000, 8'd1, 8'd3, 3'd1, 3'd2, 1'b1}; // prev I -> D
    vecs[7] = '{1, 0, 32'h5000, 32'h0,    8'd1, 8'd0, 3'd1, 3'd0, 1'b0}; // -> I

    tick();
    tick();
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_rready", m_rready, 1'b0);
    check("rst_arready", {i_arready, d_arready}, 2'b00);
    check("rst_rvalid", {i_rvalid, d_rvalid, i_rlast, d_rlast}, 4'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      run_burst(vecs[k], -1, 1'b0, -1, 0, 1'b0);
    end

    // Owner holds rready low three cycles on beat 1; count must not move.
    v = '{1, 0, 32'h7000, 32'h0, 8'd3, 8'd0, 3'd2, 3'd0, 1'b0};
    run_burst(v, -1, 1'b0, 1, 3, 1'b0);

    // rlast on beat 3 of an 8-beat burst: sticky error, then a clean burst.
    v = '{1, 0, 32'h8000, 32'h0, 8'd7, 8'd0, 3'd2, 3'd0, 1'b0};
    run_burst(v, 2, 1'b0, -1, 0, 1'b1);
    v = '{0, 1, 32'h0, 32'h9000, 8'd0, 8'd1, 3'd0, 3'd2, 1'b1};
    run_burst(v, -1, 1'b0, -1, 0, 1'b1);

    // Reset on beat 2 of a D burst; stray beats afterwards are not accepted.
    d_araddr = 32'hA000; d_arlen = 8'd3; d_arsize = 3'd2; d_arvalid = 1'b1;
    d_rready = 1'b1; i_rready = 1'b1;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    d_arvalid = 1'b0;
    m_rid = 4'd1; m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'h1111_0000;
    tick();
    m_rdata = 32'h1111_0001;
    tick();
    m_rdata = 32'h1111_0002;
    rst = 1'b1;
    #1;
    check("prerst_d_rvalid", d_rvalid, 1'b1);
    tick();
    check("rst_mid_m_rready", m_rready, 1'b0);
    check("rst_mid_d_rvalid", d_rvalid, 1'b0);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    check("rst_mid_err", err, 1'b0);
    check("rst_mid_arvalid", m_arvalid, 1'b0);
    rst = 1'b0;
    tick();
    check("after_rst_m_rready", m_rready, 1'b0);
    check("after_rst_d_rvalid", d_rvalid, 1'b0);
    m_rvalid = 1'b0;

    // Tie right after reset goes to D again; then I with a wrong returned ID.
    v = '{1, 1, 32'hB000, 32'hC000, 8'd1, 8'd1, 3'd2, 3'd2, 1'b1};
    run_burst(v, -1, 1'b0, -1, 0, 1'b0);
    v = '{1, 0, 32'hB000, 32'h0, 8'd1, 8'd0, 3'd2, 3'd0, 1'b0};
    run_burst(v, -1, 1'b1, -1, 0, 1'b1);
    tick();
    check("err_sticky", err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
